// File: rtl/shifter_seq_pkg.sv
// shifter_seq shared definitions: mode encodings and FSM state type.
// Used by shifter_seq (option macro SHIFTER_SEQ_BARREL_EN) and shifter_step.
package shifter_seq_pkg;

  localparam logic [2:0] MODE_ROL  = 3'd0;
  localparam logic [2:0] MODE_SHLC = 3'd1;
  localparam logic [2:0] MODE_ROR  = 3'd2;
  localparam logic [2:0] MODE_SHRC = 3'd3;
  localparam logic [2:0] MODE_LOAD = 3'd4;
  localparam logic [2:0] MODE_SAR  = 3'd5;
  localparam logic [2:0] MODE_SHL0 = 3'd6;
  localparam logic [2:0] MODE_NOP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/shifter_step.sv
// shifter_step: combinational one-bit rotate/shift step.
// Produces the next register value and the bit removed by this step.
module shifter_step
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode,
  input  logic             fill,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic             out_bit
);

  always_comb begin
    result  = data;
    out_bit = 1'b0;
    unique case (mode)
      MODE_ROL: begin
        result  = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit = data[WIDTH-1];
      end
      MODE_SHLC: begin
        result  = {data[WIDTH-2:0], fill};
        out_bit = data[WIDTH-1];
      end
      MODE_ROR: begin
        result  = {data[0], data[WIDTH-1:1]};
        out_bit = data[0];
      end
      MODE_SHRC: begin
        result  = {fill, data[WIDTH-1:1]};
        out_bit = data[0];
      end
      MODE_SAR: begin
        result  = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit = data[0];
      end
      MODE_SHL0: begin
        result  = {data[WIDTH-2:0], 1'b0};
        out_bit = data[WIDTH-1];
      end
      default: begin
        result  = data;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-mode rotate/shift register with start/busy/done.
// Define SHIFTER_SEQ_BARREL_EN for a single-cycle barrel datapath.
module shifter_seq
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             cin,
  input  logic [WIDTH-1:0] indata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outdata,
  output logic             cout
);

  state_t           state;
  logic [2:0]       mode_q;
  logic             cin_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_d;
  logic             step_o;
  logic             accept;
  logic             quick;

  assign accept = start && (state != RUN);
  assign quick  = (mode == MODE_LOAD) || (mode == MODE_NOP) ||
                  (amt == '0);

  shifter_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_q),
    .fill    (cin_q),
    .data    (outdata),
    .result  (step_d),
    .out_bit (step_o)
  );

`ifdef SHIFTER_SEQ_BARREL_EN
  logic [WIDTH-1:0] b_data;
  logic             b_cout;
  logic [31:0]      a32;
  logic [31:0]      rot;
  logic             fill;
  logic [WIDTH-1:0] ones;
  logic [WIDTH:0]   tl;
  logic [WIDTH:0]   tr;

  // Closed form of amt repeated steps; amt beyond WIDTH saturates to fill.
  always_comb begin
    a32    = 32'(amt);
    rot    = a32 % 32'(WIDTH);
    ones   = '1;
    fill   = 1'b0;
    tl     = '0;
    tr     = '0;
    b_data = outdata;
    b_cout = cout;
    unique case (mode)
      MODE_ROL: begin
        b_data = (outdata << rot) | (outdata >> (32'(WIDTH) - rot));
        b_cout = b_data[0];
      end
      MODE_ROR: begin
        b_data = (outdata >> rot) | (outdata << (32'(WIDTH) - rot));
        b_cout = b_data[WIDTH-1];
      end
      MODE_SHLC, MODE_SHL0: begin
        fill   = (mode == MODE_SHLC) ? cin : 1'b0;
        b_data = (outdata << a32) | (fill ? ~(ones << a32) : '0);
        tl     = {1'b0, outdata} << a32;
        b_cout = (a32 > 32'(WIDTH)) ? fill : tl[WIDTH];
      end
      MODE_SHRC, MODE_SAR: begin
        fill   = (mode == MODE_SHRC) ? cin : outdata[WIDTH-1];
        b_data = (outdata >> a32) | (fill ? ~(ones >> a32) : '0);
        tr     = {outdata, 1'b0} >> a32;
        b_cout = (a32 > 32'(WIDTH)) ? fill : tr[0];
      end
      MODE_LOAD: begin
        b_data = indata;
        b_cout = 1'b0;
      end
      default: begin
        b_data = outdata;
        b_cout = cout;
      end
    endcase
    if (a32 == 32'd0 && mode != MODE_LOAD) begin
      b_data = outdata;
      b_cout = cout;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_NOP;
      cin_q   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      outdata <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mode_q <= mode;
        cin_q  <= cin;
        cnt    <= amt;
`ifdef SHIFTER_SEQ_BARREL_EN
        outdata <= b_data;
        cout    <= b_cout;
        state   <= DONE;
        done    <= 1'b1;
        busy    <= 1'b0;
`else
        if (mode == MODE_LOAD) begin
          outdata <= indata;
          cout    <= 1'b0;
        end
        if (quick) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
`endif
      end else if (state == RUN) begin
        outdata <= step_d;
        cout    <= step_o;
        cnt     <= cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: scoreboard bench for shifter_seq, WIDTH=16.
// Expected results are queued at issue and compared on done.
module tb_shifter_seq;
  import shifter_seq_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        cout;
    int          lat;
    int          nb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [4:0]  amt = '0;
  logic        cin = 1'b0;
  logic [15:0] indata = '0;
  logic        busy;
  logic        done;
  logic [15:0] outdata;
  logic        cout;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [15:0] m_reg = '0;
  logic        m_cout = 1'b0;

  shifter_seq #(.WIDTH(16), .AMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .amt     (amt),
    .cin     (cin),
    .indata  (indata),
    .busy    (busy),
    .done    (done),
    .outdata (outdata),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_step(input logic [2:0] md,
                                           input logic c,
                                           input logic [15:0] d);
    case (md)
      MODE_ROL:  return {d[15], d[14:0], d[15]};
      MODE_SHLC: return {d[15], d[14:0], c};
      MODE_ROR:  return {d[0], d[0], d[15:1]};
      MODE_SHRC: return {d[0], c, d[15:1]};
      MODE_SAR:  return {d[0], d[15], d[15:1]};
      MODE_SHL0: return {d[15], d[14:0], 1'b0};
      default:   return {1'b0, d};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [2:0] md, input logic [4:0] a,
                        input logic c, input logic [15:0] din,
                        input bit poke);
    exp_t e;
    exp_t g;
    int   k;
    int   nb;
    bit   q;
    bit   pk;
    q  = (md == MODE_LOAD) || (md == MODE_NOP) || (a == 0);
    pk = poke;
`ifdef SHIFTER_SEQ_BARREL_EN
    q  = 1'b1;
    pk = 1'b0;
`endif
    if (md == MODE_LOAD) begin
      m_reg  = din;
      m_cout = 1'b0;
    end else if (md != MODE_NOP) begin
      for (int i = 0; i < int'(a); i++)
        {m_cout, m_reg} = ref_step(md, c, m_reg);
    end
    e.data = m_reg;
    e.cout = m_cout;
    e.lat  = q ? 1 : int'(a) + 1;
    e.nb   = q ? 0 : int'(a);
    sb.push_back(e);
    start  = 1'b1;
    mode   = md;
    amt    = a;
    cin    = c;
    indata = din;
    @(posedge clk);
    #1 start = 1'b0;
    k  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (pk && k == 2) begin
        start  = 1'b1;
        mode   = MODE_LOAD;
        indata = 16'hFFFF;
      end
      if (pk && k == 3) start = 1'b0;
    end while (!done && k < 200);
    g = sb.pop_front();
    if (!done) begin
      check("timeout", 32'(k), 32'(g.lat));
    end else begin
      check("data", 32'(outdata), 32'(g.data));
      check("cout", 32'(cout), 32'(g.cout));
      check("latency", 32'(k), 32'(g.lat));
      check("busy_cycles", 32'(nb), 32'(g.nb));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(outdata), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h8001, 1'b0);
    run_op(MODE_ROL, 5'd1, 1'b0, 16'h0, 1'b0);
    check("rol1_val", 32'(outdata), 32'h0003);
    check("rol1_cout", 32'(cout), 32'h1);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h00F0, 1'b0);
    run_op(MODE_SHRC, 5'd4, 1'b1, 16'h0, 1'b0);
    check("shrc_val", 32'(outdata), 32'hF00F);
    check("shrc_cout", 32'(cout), 32'h0);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h8010, 1'b0);
    run_op(MODE_SAR, 5'd3, 1'b0, 16'h0, 1'b0);
    check("sar_val", 32'(outdata), 32'hF002);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h0001, 1'b0);
    run_op(MODE_ROL, 5'd17, 1'b0, 16'h0, 1'b0);
    check("rol17_val", 32'(outdata), 32'h0002);
    check("rol17_cout", 32'(cout), 32'h0);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h9234, 1'b0);
    run_op(MODE_ROL, 5'd1, 1'b0, 16'h0, 1'b0);
    run_op(MODE_ROR, 5'd0, 1'b0, 16'h0, 1'b0);
    check("amt0_val", 32'(outdata), 32'h2469);
    check("amt0_cout", 32'(cout), 32'h1);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h0F0F, 1'b0);
    run_op(MODE_ROR, 5'd5, 1'b0, 16'h0, 1'b1);
    check("poke_val", 32'(outdata), 32'h7878);

    run_op(MODE_LOAD, 5'd0, 1'b0, 16'hFFFF, 1'b0);
    start = 1'b1;
    mode  = MODE_SHL0;
    amt   = 5'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 32'(outdata), 32'h0);
    check("mid_rst_cout", 32'(cout), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    rst_n  = 1'b1;
    m_reg  = '0;
    m_cout = 1'b0;
    @(negedge clk);
    run_op(MODE_LOAD, 5'd0, 1'b0, 16'h00A5, 1'b0);
    run_op(MODE_SHL0, 5'd3, 1'b0, 16'h0, 1'b0);
    check("shl0_val", 32'(outdata), 32'h0528);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 20)),
             1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
